// File: rtl/scan_select_sequencer_if.sv
// Control/status bundle between a scan controller and the sequencer.
// Ports: start/stop/hold/mode requests in; a/b/valid/busy/done status out.
interface scan_select_sequencer_if;
  logic start;
  logic stop;
  logic hold;
  logic mode;
  logic a;
  logic b;
  logic valid;
  logic busy;
  logic done;

  modport master (
    output start, stop, hold, mode,
    input  a, b, valid, busy, done
  );

  modport slave (
    input  start, stop, hold, mode,
    output a, b, valid, busy, done
  );
endinterface

// File: rtl/scan_select_sequencer.sv
// Steps the 2-bit decoder select {a,b} 00->11, DWELL cycles per code.
// Ports: clk, rst (sync, active-high), bus (slave: ctrl in, status out).
module scan_select_sequencer #(
  parameter int DWELL = 4,
  parameter int CW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  scan_select_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        code_d = '0;
        cnt_d  = '0;
        if (bus.start && !bus.stop) begin
          state_d = SCAN;
          mode_d  = bus.mode;
        end
      end
      SCAN: begin
        if (bus.stop) begin
          state_d = IDLE;
          code_d  = '0;
          cnt_d   = '0;
        end else if (bus.hold) begin
          state_d = SCAN;
        end else if (cnt_q != LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (code_q != 2'b11) begin
            code_d = code_q + 2'b01;
          end else if (mode_q) begin
            code_d = 2'b00;
          end else begin
            state_d = IDLE;
            code_d  = 2'b00;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Code is forced to 00 outside SCAN, so a/b need no state gating.
  assign bus.a     = code_q[1];
  assign bus.b     = code_q[0];
  assign bus.valid = (state_q == SCAN);
  assign bus.busy  = (state_q == SCAN);
  assign bus.done  = done_q;

endmodule
